// File: rtl/clfsr_decrypt.sv
// Streaming chaotic-LFSR image decryptor: regenerates the keystream from a seed
// and XORs it onto incoming R/G/B pixels through a one-entry output register.
module clfsr_decrypt #(
  parameter int unsigned NUM_PIXELS   = 65536,
  parameter logic [31:0] TAPS         = 32'h80200003,
  parameter logic [31:0] DEFAULT_SEED = 32'hACE1ACE1,
  parameter int unsigned WARMUP       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [31:0]                     seed,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [7:0]                      in_r,
  input  logic [7:0]                      in_g,
  input  logic [7:0]                      in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [7:0]                      out_r,
  output logic [7:0]                      out_g,
  output logic [7:0]                      out_b,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(NUM_PIXELS+1)-1:0] pix_count
);

  localparam int unsigned CW = $clog2(NUM_PIXELS + 1);
  localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [CW-1:0] PIX_LAST  = CW'(NUM_PIXELS - 1);
  localparam logic [WW-1:0] WARM_LAST = (WARMUP > 0) ? WW'(WARMUP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WARM, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_lfsr;
  logic [WW-1:0] r_warm;
  logic [CW-1:0] r_pix;
  logic        r_out_valid;
  logic [7:0]  r_out_r;
  logic [7:0]  r_out_g;
  logic [7:0]  r_out_b;

  logic [31:0] w_lfsr_step;
  logic        w_start_ok;
  logic        w_accept;
  logic        w_out_drain;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign in_ready    = (r_state == S_RUN) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_out_drain = r_out_valid && out_ready;

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_g     = r_out_g;
  assign out_b     = r_out_b;
  assign pix_count = r_pix;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        busy        = 1'b1;
        w_state_nxt = (WARMUP > 0) ? S_WARM : S_RUN;
      end
      S_WARM: begin
        busy = 1'b1;
        if (r_warm == WARM_LAST) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_accept && (r_pix == PIX_LAST)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!r_out_valid || out_ready) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr      <= '0;
      r_warm      <= '0;
      r_pix       <= '0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_g     <= '0;
      r_out_b     <= '0;
    end else begin
      // Keystream advances only during warm-up and on accepted pixels.
      if (w_start_ok)
        r_lfsr <= (seed == '0) ? DEFAULT_SEED : seed;
      else if ((r_state == S_WARM) || w_accept)
        r_lfsr <= w_lfsr_step;

      if (r_state == S_LOAD)      r_warm <= '0;
      else if (r_state == S_WARM) r_warm <= r_warm + 1'b1;

      if (w_start_ok)    r_pix <= '0;
      else if (w_accept) r_pix <= r_pix + 1'b1;

      // An accept that coincides with a drain reloads the register in place.
      if (w_accept) begin
        r_out_r     <= in_r ^ r_lfsr[7:0];
        r_out_g     <= in_g ^ r_lfsr[15:8];
        r_out_b     <= in_b ^ r_lfsr[23:16];
        r_out_valid <= 1'b1;
      end else if (w_out_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clfsr_decrypt.sv
// Bench for clfsr_decrypt: fixed vectors on a 2-pixel/no-warm-up instance and
// randomized round-trip frames on a 16-pixel/16-step warm-up instance.
module tb_clfsr_decrypt;

  localparam logic [31:0] TAPS     = 32'h80200003;
  localparam logic [31:0] DEF_SEED = 32'hACE1ACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [31:0] seed;
  logic        in_valid, out_ready;
  logic [7:0]  in_r, in_g, in_b;

  logic       a_in_ready, a_out_valid, a_busy, a_done;
  logic [7:0] a_out_r, a_out_g, a_out_b;
  logic [1:0] a_pix;
  logic       b_in_ready, b_out_valid, b_busy, b_done;
  logic [7:0] b_out_r, b_out_g, b_out_b;
  logic [4:0] b_pix;

  always #5 clk = ~clk;

  clfsr_decrypt #(.NUM_PIXELS(2), .WARMUP(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_r(a_out_r), .out_g(a_out_g), .out_b(a_out_b),
    .busy(a_busy), .done(a_done), .pix_count(a_pix)
  );

  clfsr_decrypt #(.NUM_PIXELS(16), .WARMUP(16)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_r(b_out_r), .out_g(b_out_g), .out_b(b_out_b),
    .busy(b_busy), .done(b_done), .pix_count(b_pix)
  );

  // Selected-instance view; pixels packed as {b,g,r} so key bytes line up with lfsr[23:0].
  logic        sel;
  logic        d_in_ready, d_out_valid, d_busy, d_done;
  logic [23:0] d_out;
  logic [31:0] d_pix;
  always_comb begin
    if (sel) begin
      d_in_ready = b_in_ready; d_out_valid = b_out_valid; d_busy = b_busy; d_done = b_done;
      d_out = {b_out_b, b_out_g, b_out_r}; d_pix = 32'(b_pix);
    end else begin
      d_in_ready = a_in_ready; d_out_valid = a_out_valid; d_busy = a_busy; d_done = a_done;
      d_out = {a_out_b, a_out_g, a_out_r}; d_pix = 32'(a_pix);
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  // Reference model state
  int unsigned m_w, m_n, m_acc, m_edges;
  bit          m_busy, m_done;
  logic [23:0] q[$];
  logic [23:0] in_pix[16];
  logic [23:0] exp_pix[16];

  typedef struct {
    logic [31:0] seed;
    logic [23:0] cin;
    logic [23:0] pout;
  } vec_t;
  vec_t vec[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_after(input logic [31:0] sd, input int unsigned n);
    logic [31:0] s;
    s = (sd == 32'h0) ? DEF_SEED : sd;
    for (int unsigned i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    return s;
  endfunction

  // Encryptor model: ciphertext = plaintext ^ keystream; expected decrypt output = plaintext.
  task automatic prep_roundtrip(input logic [31:0] sd);
    logic [31:0] k;
    for (int unsigned i = 0; i < m_n; i++) begin
      exp_pix[i] = 24'($urandom);
      k          = lfsr_after(sd, m_w + i);
      in_pix[i]  = exp_pix[i] ^ k[23:0];
    end
    seed = sd;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cyc(input bit st, input bit iv, input bit ordy);
    bit busy0, qne, run, rdy, acc, oh;
    int unsigned idx;
    idx = (m_acc < m_n) ? m_acc : 0;
    start_a = st && !sel;
    start_b = st && sel;
    in_valid = iv;
    {in_b, in_g, in_r} = in_pix[idx];
    out_ready = ordy;
    #1;
    busy0 = m_busy;
    qne   = (q.size() != 0);
    run   = m_busy && (m_edges >= m_w + 1) && (m_acc < m_n);
    rdy   = run && (!qne || ordy);
    chk("in_ready", 32'(d_in_ready), 32'(rdy));
    chk("out_valid", 32'(d_out_valid), 32'(qne));
    if (qne) chk("out_pixel", 32'(d_out), 32'(q[0]));
    chk("pix_count", d_pix, m_acc);
    chk("busy", 32'(d_busy), 32'(m_busy));
    chk("done", 32'(d_done), 32'(m_done));
    acc = iv && rdy;
    oh  = qne && ordy;
    if (busy0 && (m_acc == m_n) && (!qne || ordy)) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
    if (oh) void'(q.pop_front());
    if (acc) begin
      q.push_back(exp_pix[idx]);
      m_acc++;
    end
    m_edges++;
    if (st && !busy0) begin
      m_busy = 1'b1; m_done = 1'b0; m_acc = 0; m_edges = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_frame(input int unsigned vpct, input int unsigned rpct);
    int unsigned n = 0;
    while (!m_done && n < 400) begin
      cyc(1'b0, $urandom_range(0, 99) < vpct, $urandom_range(0, 99) < rpct);
      n++;
    end
    n_checks++;
    if (!m_done) begin
      n_err++;
      $display("FAIL frame_timeout: got %0d pixels, expected %0d", m_acc, m_n);
    end
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(d_out_valid), 32'h0);
    chk("rst_out_pixel", 32'(d_out), 32'h0);
    chk("rst_in_ready", 32'(d_in_ready), 32'h0);
    chk("rst_busy", 32'(d_busy), 32'h0);
    chk("rst_done", 32'(d_done), 32'h0);
    chk("rst_pix_count", d_pix, 32'h0);
    q.delete();
    m_busy = 1'b0; m_done = 1'b0; m_acc = 0; m_edges = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic use_dut(input bit s);
    sel = s;
    m_w = s ? 16 : 0;
    m_n = s ? 16 : 2;
    do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    vec[0] = '{32'h00000001, 24'h302010, 24'h302011};
    vec[1] = '{32'h00000001, 24'h000000, 24'h200003};
    vec[2] = '{32'h00000000, 24'h000000, 24'hE1ACE1};
    vec[3] = '{32'h00000000, 24'h000000, 24'h50D673};
    vec[4] = '{32'hFFFFFFFF, 24'h563412, 24'hA9CBED};
    vec[5] = '{32'hFFFFFFFF, 24'hFFFFFF, 24'h200003};
    vec[6] = '{32'h00000001, 24'hFF55AA, 24'hFF55AB};
    vec[7] = '{32'h00000001, 24'h200003, 24'h000000};

    rst = 1'b0; sel = 1'b0; seed = '0;
    start_a = 1'b0; start_b = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    @(negedge clk);

    // Fixed vectors, two-pixel frames, no warm-up
    use_dut(1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 2; p++) begin
        in_pix[p]  = vec[2*f+p].cin;
        exp_pix[p] = vec[2*f+p].pout;
      end
      seed = vec[2*f].seed;
      cyc(1'b1, 1'b0, 1'b1);
      if (f < 3) finish_frame(100, 100);
      else       finish_frame(60, 50);
    end

    // Backpressure: output stalled for five cycles with input pending
    use_dut(1'b1);
    prep_roundtrip(32'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b1);
    n = 0;
    while (m_acc < 1 && n < 100) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    finish_frame(100, 100);

    // Round trip with warm-up and random handshakes
    prep_roundtrip(32'h12345678);
    cyc(1'b1, 1'b0, 1'b1);
    finish_frame(70, 60);

    // Reset mid-frame, then restart with the same seed
    prep_roundtrip(32'h0BADF00D);
    cyc(1'b1, 1'b0, 1'b1);
    n = 0;
    while (m_acc < 3 && n < 200) begin cyc(1'b0, 1'b1, 1'($urandom_range(0, 1))); n++; end
    do_reset();
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    finish_frame(100, 100);

    // Start ignored while running; start from DONE begins a new frame
    prep_roundtrip(32'hCAFE0001);
    cyc(1'b1, 1'b0, 1'b1);
    n = 0;
    while (m_acc < 2 && n < 200) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    finish_frame(80, 80);
    prep_roundtrip(32'h00000000);
    cyc(1'b1, 1'b0, 1'b1);
    finish_frame(80, 70);

    // Random seeds and handshake densities
    for (int f = 0; f < 3; f++) begin
      prep_roundtrip($urandom);
      cyc(1'b1, 1'b0, 1'b1);
      finish_frame($urandom_range(30, 100), $urandom_range(30, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/clfsr_decrypt.md
Name: clfsr_decrypt

Overview:
- Streaming decryptor for the chaotic-LFSR image cipher. It regenerates the encryptor's keystream from the shared seed and XORs it onto incoming encrypted R/G/B pixels to recover plaintext.
- Sits downstream of the encrypted-image store. It consumes one RGB pixel per handshake and emits the decrypted pixel through a one-entry output register.
- Asserts done after NUM_PIXELS pixels have been delivered.

Parameters:
- NUM_PIXELS, 65536: pixels per image; the pixel counter terminates at this value.
- TAPS, 32'h80200003: Galois LFSR feedback mask, x^32+x^22+x^2+x+1.
- DEFAULT_SEED, 32'hACE1ACE1: seed substituted when the seed input is 0, to avoid lock-up.
- WARMUP, 16: LFSR steps discarded after seed load, before the first pixel.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when in IDLE or DONE.
- seed  in  32  keystream seed; sampled on the accepted start.
- in_valid  in  1  encrypted pixel valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_r, in_g, in_b  in  8 each  encrypted pixel channels.
- out_valid  out  1  decrypted pixel valid.
- out_ready  in  1  downstream accepts the output pixel.
- out_r, out_g, out_b  out  8 each  decrypted pixel channels.
- busy  out  1  high in LOAD, WARM, RUN, DRAIN.
- done  out  1  high in DONE, held until the next start.
- pix_count  out  $clog2(NUM_PIXELS+1)  number of pixels accepted this frame.

Behaviour:
- Reset (rst=0, async): state=IDLE, lfsr=0, warm counter=0, pix_count=0, out_valid=0, out_r/g/b=0, in_ready=0, busy=0, done=0.
- LFSR step, Galois right shift:
  - next = (s>>1) ^ TAPS when s[0]=1;
  - next = s>>1 otherwise.
- States:
  - IDLE/DONE: on start, lfsr <= (seed==0 ? DEFAULT_SEED : seed), pix_count <= 0, done <= 0, go to LOAD. A start in any other state is ignored.
  - LOAD: one cycle. Go to WARM if WARMUP>0, else to RUN.
  - WARM: step the LFSR once per cycle for exactly WARMUP cycles, then go to RUN. in_ready=0.
  - RUN:
    - in_ready = !out_valid || out_ready (combinational).
    - On accept (in_valid && in_ready):
      - out_r <= in_r ^ lfsr[7:0], out_g <= in_g ^ lfsr[15:8], out_b <= in_b ^ lfsr[23:16];
      - out_valid <= 1, lfsr steps once, pix_count increments.
    - The key used is the pre-step state. lfsr[31:24] is unused.
    - When the accept makes pix_count reach NUM_PIXELS, go to DRAIN.
  - DRAIN: in_ready=0. When out_valid=0, or out_valid && out_ready, go to DONE.
  - DONE: done=1, busy=0, in_ready=0.
- Output register:
  - out_valid clears on out_valid && out_ready with no simultaneous accept.
  - A simultaneous accept and drain reloads the register, so out_valid stays 1. Full throughput is 1 pixel/cycle.
- Latency: the decrypted pixel is visible the cycle after the input accept.
- Backpressure:
  - While out_valid && !out_ready, out_r/g/b hold stable and in_ready=0.
  - in_valid without in_ready is not consumed, and the LFSR does not step.
- The LFSR steps only in WARM, and on accepts in RUN.
- Reset mid-frame: returns to IDLE immediately. Any pixel in flight is discarded and out_valid drops asynchronously.
- Symmetric with the encryptor: same seed, TAPS and WARMUP produce the identical keystream. Decrypt(Encrypt(p)) = p.

Test Plan:
1. WARMUP=0, seed=1, NUM_PIXELS=2. Inputs (10,20,30) then (0,0,0), out_ready=1 → outputs (11,20,30) then (03,00,20). done rises one cycle after the second output is accepted. pix_count=2.
2. seed=0, WARMUP=0 → first key equals DEFAULT_SEED. Input (00,00,00) → output (E1,AC,E1).
3. Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0, out_* stable, LFSR not stepping. Release → outputs continue in order with no drop or duplicate.
4. Round trip: drive a 16-pixel frame from a reference-model encryptor (seed 32'h12345678, WARMUP=16) → every output equals the original plaintext. done=1.
5. Assert rst=0 in RUN after 3 pixels → all outputs read zero within the same cycle. A new start with the same seed reproduces pixel-1 keys.
6. Pulse start while in RUN → ignored (pix_count and keystream unchanged). Pulse start in DONE → done clears and a new frame begins.
